lab3_burst_packer: RTL and testbench

Downstream stage of the LAB3 core. Consumes its 3-bit OUT/OUT_VALID symbol stream and groups each contiguous OUT_VALID burst into one packet. A packet carries the packed symbols, the symbol count, the symbol sum and a truncation flag. Packets go out on a valid/ready interface through a small show-ahead queue, so a stalled consumer never back-pressures LAB3.

---
 rtl/lab3_pkg.sv | 23 ++
 rtl/lab3_pkt_fifo.sv | 66 ++++++
 rtl/lab3_burst_packer.sv | 108 ++++++++++
 tb/tb_lab3_burst_packer.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/lab3_pkg.sv
// Shared widths, FSM state and packet payload for the LAB3 burst packer.
package lab3_pkg;

    localparam int unsigned SYM_W   = 3;
    localparam int unsigned MAX_SYM = 8;
    localparam int unsigned LEN_W   = 4;
    localparam int unsigned SUM_W   = 6;
    localparam int unsigned DATA_W  = SYM_W * MAX_SYM;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        SKIP    = 2'd2
    } state_t;

    typedef struct packed {
        logic [DATA_W-1:0] data;
        logic [LEN_W-1:0]  len;
        logic [SUM_W-1:0]  sum;
        logic              trunc;
    } pkt_t;

endpackage

// File: rtl/lab3_pkt_fifo.sv
// Show-ahead packet queue built as a shift register: slot 0 is always the head,
// so the head is a plain register and reads as zero whenever the queue is empty.
module lab3_pkt_fifo
    import lab3_pkg::*;
#(
    parameter int unsigned DEPTH = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic push,
    input  pkt_t wr_pkt,
    input  logic pop,
    output pkt_t head,
    output logic head_valid,
    output logic empty,
    output logic full
);

    pkt_t             mem     [DEPTH];
    pkt_t             nxt_mem [DEPTH];
    logic [DEPTH-1:0] vld;
    logic [DEPTH-1:0] nxt_vld;
    logic             placed;

    // Pop shifts everything down one slot; push then lands in the first free slot.
    always_comb begin
        nxt_mem = mem;
        nxt_vld = vld;
        placed  = 1'b0;
        if (pop && vld[0]) begin
            for (int i = 0; i < int'(DEPTH) - 1; i++) begin
                nxt_mem[i] = mem[i+1];
                nxt_vld[i] = vld[i+1];
            end
            nxt_mem[DEPTH-1] = '0;
            nxt_vld[DEPTH-1] = 1'b0;
        end
        if (push) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                if (!placed && !nxt_vld[i]) begin
                    nxt_mem[i] = wr_pkt;
                    nxt_vld[i] = 1'b1;
                    placed     = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem[i] <= '0;
            end
            vld <= '0;
        end else begin
            mem <= nxt_mem;
            vld <= nxt_vld;
        end
    end

    assign head       = mem[0];
    assign head_valid = vld[0];
    assign empty      = ~vld[0];
    assign full       = vld[DEPTH-1];

endmodule

// File: rtl/lab3_burst_packer.sv
// Groups each contiguous in_valid burst of 3-bit LAB3 symbols into one packet
// and queues it for a valid/ready consumer without ever stalling LAB3.
module lab3_burst_packer
    import lab3_pkg::*;
#(
    parameter int unsigned DEPTH = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    input  logic [SYM_W-1:0]  input_sym,
    output logic [DATA_W-1:0] pkt_data,
    output logic [LEN_W-1:0]  pkt_len,
    output logic [SUM_W-1:0]  pkt_sum,
    output logic              pkt_trunc,
    output logic              pkt_valid,
    input  logic              pkt_ready,
    output logic              drop,
    output logic              busy
);

    state_t state;
    pkt_t   asm_pkt;
    pkt_t   head;
    logic   commit_c;
    logic   pop_c;
    logic   push_c;
    logic   fifo_empty;
    logic   fifo_full;

    // A burst commits on the first idle edge; a full queue only loses it if nothing pops.
    assign commit_c = (state != IDLE) && !in_valid;
    assign pop_c    = pkt_ready && !fifo_empty;
    assign push_c   = commit_c && !(fifo_full && !pop_c);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            asm_pkt <= '0;
            busy    <= 1'b0;
            drop    <= 1'b0;
        end else begin
            drop <= commit_c && fifo_full && !pop_c;
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        asm_pkt.data  <= DATA_W'(input_sym);
                        asm_pkt.len   <= LEN_W'(1);
                        asm_pkt.sum   <= SUM_W'(input_sym);
                        asm_pkt.trunc <= 1'b0;
                        state         <= COLLECT;
                        busy          <= 1'b1;
                    end
                end
                COLLECT: begin
                    if (!in_valid) begin
                        asm_pkt <= '0;
                        state   <= IDLE;
                        busy    <= 1'b0;
                    end else if (asm_pkt.len < LEN_W'(MAX_SYM)) begin
                        for (int k = 0; k < int'(MAX_SYM); k++) begin
                            if (asm_pkt.len == LEN_W'(k)) begin
                                asm_pkt.data[k*SYM_W +: SYM_W] <= input_sym;
                            end
                        end
                        asm_pkt.len <= asm_pkt.len + LEN_W'(1);
                        asm_pkt.sum <= asm_pkt.sum + SUM_W'(input_sym);
                    end else begin
                        asm_pkt.trunc <= 1'b1;
                        state         <= SKIP;
                    end
                end
                SKIP: begin
                    if (!in_valid) begin
                        asm_pkt <= '0;
                        state   <= IDLE;
                        busy    <= 1'b0;
                    end
                end
                default: begin
                    asm_pkt <= '0;
                    state   <= IDLE;
                    busy    <= 1'b0;
                end
            endcase
        end
    end

    lab3_pkt_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk        (clk),
        .rst_n      (rst_n),
        .push       (push_c),
        .wr_pkt     (asm_pkt),
        .pop        (pop_c),
        .head       (head),
        .head_valid (pkt_valid),
        .empty      (fifo_empty),
        .full       (fifo_full)
    );

    assign pkt_data  = head.data;
    assign pkt_len   = head.len;
    assign pkt_sum   = head.sum;
    assign pkt_trunc = head.trunc;

endmodule

// File: tb/tb_lab3_burst_packer.sv
// Directed bench for lab3_burst_packer with hand-computed expected packets.
module tb_lab3_burst_packer;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic [2:0]  input_sym;
    logic [23:0] pkt_data;
    logic [3:0]  pkt_len;
    logic [5:0]  pkt_sum;
    logic        pkt_trunc;
    logic        pkt_valid;
    logic        pkt_ready;
    logic        drop;
    logic        busy;

    int n_vec;
    int n_err;

    lab3_burst_packer #(
        .DEPTH (2)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .input_sym (input_sym),
        .pkt_data  (pkt_data),
        .pkt_len   (pkt_len),
        .pkt_sum   (pkt_sum),
        .pkt_trunc (pkt_trunc),
        .pkt_valid (pkt_valid),
        .pkt_ready (pkt_ready),
        .drop      (drop),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Wait for the falling edge, then present inputs for the next rising edge.
    task automatic cyc(input logic v, input logic [2:0] s);
        @(negedge clk);
        in_valid  = v;
        input_sym = s;
    endtask

    task automatic check_pkt(input string tag, input logic [23:0] d, input logic [3:0] l,
                             input logic [5:0] s, input logic t);
        check({tag, ".valid"}, 32'(pkt_valid), 32'd1);
        check({tag, ".data"},  32'(pkt_data),  32'(d));
        check({tag, ".len"},   32'(pkt_len),   32'(l));
        check({tag, ".sum"},   32'(pkt_sum),   32'(s));
        check({tag, ".trunc"}, 32'(pkt_trunc), 32'(t));
    endtask

    task automatic check_empty(input string tag);
        check({tag, ".valid"}, 32'(pkt_valid), 32'd0);
        check({tag, ".data"},  32'(pkt_data),  32'd0);
        check({tag, ".len"},   32'(pkt_len),   32'd0);
        check({tag, ".sum"},   32'(pkt_sum),   32'd0);
        check({tag, ".trunc"}, 32'(pkt_trunc), 32'd0);
    endtask

    initial begin
        n_vec     = 0;
        n_err     = 0;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        input_sym = 3'd0;
        pkt_ready = 1'b1;
        repeat (2) @(negedge clk);
        check_empty("rst");
        check("rst.busy", 32'(busy), 32'd0);
        check("rst.drop", 32'(drop), 32'd0);
        rst_n = 1'b1;

        // Burst 5,2,7
        cyc(1'b1, 3'd5);
        cyc(1'b1, 3'd2);
        cyc(1'b1, 3'd7);
        cyc(1'b0, 3'd0);
        check("b1.valid_early", 32'(pkt_valid), 32'd0);
        check("b1.busy", 32'(busy), 32'd1);
        cyc(1'b0, 3'd0);
        check_pkt("b1", 24'h0001D5, 4'd3, 6'd14, 1'b0);
        check("b1.busy_done", 32'(busy), 32'd0);
        cyc(1'b0, 3'd0);
        check_empty("b1.after");

        // Ten 7s: truncated at eight
        for (int i = 0; i < 10; i++) begin
            cyc(1'b1, 3'd7);
            if (i > 0) check("b2.busy", 32'(busy), 32'd1);
        end
        cyc(1'b0, 3'd0);
        check("b2.busy_last", 32'(busy), 32'd1);
        cyc(1'b0, 3'd0);
        check_pkt("b2", 24'hFFFFFF, 4'd8, 6'd56, 1'b1);
        cyc(1'b0, 3'd0);
        check_empty("b2.after");

        // Stalled consumer: third single-symbol packet dropped
        pkt_ready = 1'b0;
        cyc(1'b1, 3'd1);
        cyc(1'b0, 3'd0);
        cyc(1'b1, 3'd2);
        check("b3.drop0", 32'(drop), 32'd0);
        cyc(1'b0, 3'd0);
        cyc(1'b1, 3'd3);
        check("b3.drop1", 32'(drop), 32'd0);
        cyc(1'b0, 3'd0);
        check("b3.drop2", 32'(drop), 32'd0);
        cyc(1'b0, 3'd0);
        check("b3.drop_pulse", 32'(drop), 32'd1);
        check_pkt("b3.head1", 24'h000001, 4'd1, 6'd1, 1'b0);
        cyc(1'b0, 3'd0);
        check("b3.drop_end", 32'(drop), 32'd0);
        check_pkt("b3.hold", 24'h000001, 4'd1, 6'd1, 1'b0);
        pkt_ready = 1'b1;
        cyc(1'b0, 3'd0);
        check_pkt("b3.head2", 24'h000002, 4'd1, 6'd2, 1'b0);
        check("b3.drop_after", 32'(drop), 32'd0);
        cyc(1'b0, 3'd0);
        check_empty("b3.empty");

        // Back-to-back bursts with one idle edge
        cyc(1'b1, 3'd4);
        cyc(1'b1, 3'd4);
        cyc(1'b0, 3'd0);
        cyc(1'b1, 3'd6);
        check_pkt("b4.p1", 24'h000024, 4'd2, 6'd8, 1'b0);
        cyc(1'b0, 3'd0);
        check("b4.gap", 32'(pkt_valid), 32'd0);
        cyc(1'b0, 3'd0);
        check_pkt("b4.p2", 24'h000006, 4'd1, 6'd6, 1'b0);
        cyc(1'b0, 3'd0);
        check_empty("b4.after");

        // Reset mid-burst with a packet already queued
        pkt_ready = 1'b0;
        cyc(1'b1, 3'd5);
        cyc(1'b0, 3'd0);
        cyc(1'b1, 3'd1);
        cyc(1'b1, 3'd2);
        cyc(1'b1, 3'd2);
        check("b5.pre_valid", 32'(pkt_valid), 32'd1);
        check("b5.pre_busy", 32'(busy), 32'd1);
        #1 rst_n = 1'b0;
        in_valid = 1'b0;
        #1;
        check_empty("b5.rst");
        check("b5.rst_busy", 32'(busy), 32'd0);
        check("b5.rst_drop", 32'(drop), 32'd0);
        pkt_ready = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;
        in_valid  = 1'b1;
        input_sym = 3'd3;
        cyc(1'b0, 3'd0);
        check("b5.busy", 32'(busy), 32'd1);
        cyc(1'b0, 3'd0);
        check_pkt("b5", 24'h000003, 4'd1, 6'd3, 1'b0);
        cyc(1'b0, 3'd0);
        check_empty("b5.after");

        // Full queue with a pop on the commit edge: nothing lost, order kept
        pkt_ready = 1'b0;
        cyc(1'b1, 3'd1);
        cyc(1'b0, 3'd0);
        cyc(1'b1, 3'd2);
        cyc(1'b0, 3'd0);
        cyc(1'b1, 3'd3);
        cyc(1'b0, 3'd0);
        pkt_ready = 1'b1;
        check_pkt("b6.h1", 24'h000001, 4'd1, 6'd1, 1'b0);
        cyc(1'b0, 3'd0);
        check("b6.nodrop", 32'(drop), 32'd0);
        check_pkt("b6.h2", 24'h000002, 4'd1, 6'd2, 1'b0);
        cyc(1'b0, 3'd0);
        check("b6.nodrop2", 32'(drop), 32'd0);
        check_pkt("b6.h3", 24'h000003, 4'd1, 6'd3, 1'b0);
        cyc(1'b0, 3'd0);
        check_empty("b6.empty");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
